frame_rx_buffer: RTL and testbench
==================================

Name: frame_rx_buffer

Overview:
Downstream consumer of frame_decode. Collects the soc / data_valid / eoc event stream of one PCD->PICC frame into a byte buffer and computes CRC_A on the fly. On end of frame it presents the frame length, the partial-bit count, CRC status and error flags for the protocol layer. Buffered bytes are read back through a random-access read port.

Parameters:
MAX_BYTES, 64, buffer depth in bytes; must be ≥ 3.
BW, $clog2(MAX_BYTES+1), width of the byte-count outputs (derived, not overridden).

Ports:
clk  in  1  system clock.
rst_n  in  1  async active-low reset.
soc  in  1  start of frame pulse (from frame_decode).
eoc  in  1  end of frame pulse.
data  in  8  byte on data_valid; partial byte on eoc, LSb aligned.
data_bits  in  3  valid bits in data at eoc; 0 = no partial byte.
data_valid  in  1  full byte strobe.
sequence_error  in  1  sequence error pulse.
parity_error  in  1  parity error pulse.
rx_busy  out  1  frame reception in progress.
frame_done  out  1  one-cycle pulse; all result outputs valid.
frame_bytes  out  BW  stored byte count, including any partial byte.
frame_last_bits  out  3  bits in the last stored byte; 0 = full byte.
crc_ok  out  1  CRC_A residue check passed.
err_parity  out  1  parity error seen in frame.
err_sequence  out  1  sequence error seen in frame.
err_overflow  out  1  byte(s) dropped because the buffer was full.
rd_addr  in  BW  read address.
rd_data  out  8  buf[rd_addr]; combinational read; 0 if rd_addr ≥ MAX_BYTES.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - crc register is 16'h6363.
  - The byte counter is 0.
  - Buffer contents are not reset.
- State IDLE:
  - data_valid, eoc and error pulses are ignored.
  - soc → RX.
- soc in any state:
  - Clears the counter, err_* flags, frame_last_bits and crc_ok.
  - Loads crc with 16'h6363 and sets rx_busy.
  - Enters RX. An in-progress frame is aborted; no frame_done is emitted for it.
- soc has priority over every other input in the same cycle.
- State RX, data_valid without eoc:
  - If count < MAX_BYTES: buf[count] ← data, count++, crc updated with data.
  - Otherwise the byte is dropped, err_overflow is set (sticky) and the count saturates at MAX_BYTES.
- State RX, parity_error / sequence_error: set the matching sticky err_* flag. These may coincide with data_valid or eoc; the flag is still captured.
- State RX, eoc:
  - If data_bits ≠ 0 and room remains: buf[count] ← data with bits above data_bits zeroed, count++, frame_last_bits ← data_bits. No CRC update.
  - If data_bits ≠ 0 and there is no room: set err_overflow.
  - Next cycle: frame_done = 1 for exactly one cycle, rx_busy = 0, state → IDLE.
  - Result outputs (frame_bytes, frame_last_bits, crc_ok, err_*) are updated on the same edge and held until the next soc.
- data_valid together with eoc: the eoc path is taken and data_valid is ignored (frame_decode never issues both).
- CRC_A definition:
  - Polynomial x^16+x^12+x^5+1, reflected (0x8408), LSb-first.
  - Init 0x6363, no final XOR.
  - One byte per cycle, combinational 8-step update.
- crc_ok = 1 only if all of the following hold; otherwise 0:
  - crc == 16'h0000 after all full bytes, i.e. the trailing two CRC bytes were absorbed.
  - frame_bytes ≥ 3.
  - frame_last_bits == 0.
  - No err_* flag set.
- frame_bytes is the saturated counter value and never exceeds MAX_BYTES.
- rd_data: may be read at any time; contents are valid for indices < frame_bytes after frame_done. Reads during RX return partially written data.
- Reset mid-frame: immediate return to the reset state, no frame_done.

Test Plan:
- HLTA: soc, bytes 50 00 57 CD, eoc with data_bits = 0 → frame_done 1 cycle after eoc; frame_bytes = 4, crc_ok = 1, err_* = 0; rd_data @0..3 = 50 00 57 CD.
- Corrupted CRC: bytes 00 00 A0 1F → frame_bytes = 4, crc_ok = 0. Same frame with A0 1E → crc_ok = 1.
- Short frame: soc, eoc with data_bits = 7 and data = 0x26 → frame_bytes = 1, frame_last_bits = 7, rd_data @0 = 0x26, crc_ok = 0.
- Errors: bytes 93 20, then parity_error, then eoc → err_parity = 1, crc_ok = 0, frame_bytes = 2. Repeat with sequence_error → err_sequence = 1.
- Overflow, MAX_BYTES = 4: 6 bytes, eoc → frame_bytes = 4, err_overflow = 1, buf holds the first 4 bytes, crc_ok = 0.
- Abort and reset:
  - soc, 2 bytes, soc again, byte 0xAA, eoc → exactly one frame_done; frame_bytes = 1, rd_data @0 = 0xAA.
  - rst_n low mid-frame → rx_busy = 0 immediately, no frame_done.

Source files
------------

// File: rtl/frame_rx_buffer.sv
// Receive-side frame buffer: stores the byte stream of one frame, tracks CRC_A
// and error flags, and publishes the frame summary one cycle after end of frame.
module frame_rx_buffer #(
  parameter int MAX_BYTES = 64,
  localparam int BW = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          soc,
  input  logic          eoc,
  input  logic [7:0]    data,
  input  logic [2:0]    data_bits,
  input  logic          data_valid,
  input  logic          sequence_error,
  input  logic          parity_error,
  output logic          rx_busy,
  output logic          frame_done,
  output logic [BW-1:0] frame_bytes,
  output logic [2:0]    frame_last_bits,
  output logic          crc_ok,
  output logic          err_parity,
  output logic          err_sequence,
  output logic          err_overflow,
  input  logic [BW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int AW = $clog2(MAX_BYTES);
  localparam logic [15:0] CRC_INIT = 16'h6363;

  typedef enum logic {IDLE, RX} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] count_q, count_d;
  logic [15:0]   crc_q, crc_d;
  logic [2:0]    last_bits_q, last_bits_d;
  logic          crc_ok_q, crc_ok_d;
  logic          done_q, done_d;
  logic          err_par_q, err_par_d;
  logic          err_seq_q, err_seq_d;
  logic          err_ovf_q, err_ovf_d;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic [AW-1:0] wr_addr;
  logic          room;
  logic [7:0]    partial_mask;

  logic [7:0]    mem_q [MAX_BYTES];

  // Reflected CRC_A (0x8408), one byte absorbed LSb first.
  function automatic logic [15:0] crc_a_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  d);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign room         = (count_q < BW'(MAX_BYTES));
  assign wr_addr      = count_q[AW-1:0];
  assign partial_mask = 8'hFF >> (4'd8 - {1'b0, data_bits});

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    crc_d       = crc_q;
    last_bits_d = last_bits_q;
    crc_ok_d    = crc_ok_q;
    done_d      = 1'b0;
    err_par_d   = err_par_q;
    err_seq_d   = err_seq_q;
    err_ovf_d   = err_ovf_q;
    wr_en       = 1'b0;
    wr_data     = data;

    if (soc) begin
      // A new start always wins, silently discarding any frame in flight.
      state_d     = RX;
      count_d     = '0;
      crc_d       = CRC_INIT;
      last_bits_d = 3'd0;
      crc_ok_d    = 1'b0;
      err_par_d   = 1'b0;
      err_seq_d   = 1'b0;
      err_ovf_d   = 1'b0;
    end else if (state_q == RX) begin
      if (parity_error)   err_par_d = 1'b1;
      if (sequence_error) err_seq_d = 1'b1;

      if (eoc) begin
        if (data_bits != 3'd0) begin
          if (room) begin
            wr_en       = 1'b1;
            wr_data     = data & partial_mask;
            count_d     = count_q + BW'(1);
            last_bits_d = data_bits;
          end else begin
            err_ovf_d = 1'b1;
          end
        end
        // The partial byte never enters the CRC, so crc_q is already final here.
        crc_ok_d = (crc_q == 16'h0000) && (count_d >= BW'(3)) &&
                   (last_bits_d == 3'd0) &&
                   !err_par_d && !err_seq_d && !err_ovf_d;
        done_d  = 1'b1;
        state_d = IDLE;
      end else if (data_valid) begin
        if (room) begin
          wr_en   = 1'b1;
          count_d = count_q + BW'(1);
          crc_d   = crc_a_byte(crc_q, data);
        end else begin
          err_ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      crc_q       <= CRC_INIT;
      last_bits_q <= 3'd0;
      crc_ok_q    <= 1'b0;
      done_q      <= 1'b0;
      err_par_q   <= 1'b0;
      err_seq_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      crc_q       <= crc_d;
      last_bits_q <= last_bits_d;
      crc_ok_q    <= crc_ok_d;
      done_q      <= done_d;
      err_par_q   <= err_par_d;
      err_seq_q   <= err_seq_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // Byte storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr < BW'(MAX_BYTES)) rd_data = mem_q[rd_addr[AW-1:0]];
  end

  assign rx_busy         = (state_q == RX);
  assign frame_done      = done_q;
  assign frame_bytes     = count_q;
  assign frame_last_bits = last_bits_q;
  assign crc_ok          = crc_ok_q;
  assign err_parity      = err_par_q;
  assign err_sequence    = err_seq_q;
  assign err_overflow    = err_ovf_q;

endmodule

// File: tb/tb_frame_rx_buffer.sv
// Scoreboard bench for frame_rx_buffer: a frame-level model queues the expected
// summary at each end of frame; a monitor compares it when frame_done appears.
module tb_frame_rx_buffer;

  localparam int MAX = 4;
  localparam int BW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst_n, soc, eoc, data_valid, sequence_error, parity_error;
  logic [7:0]    data;
  logic [2:0]    data_bits;
  logic [BW-1:0] rd_addr;
  logic          rx_busy, frame_done, crc_ok, err_parity, err_sequence, err_overflow;
  logic [BW-1:0] frame_bytes;
  logic [2:0]    frame_last_bits;
  logic [7:0]    rd_data;

  frame_rx_buffer #(.MAX_BYTES(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .soc(soc), .eoc(eoc), .data(data),
    .data_bits(data_bits), .data_valid(data_valid),
    .sequence_error(sequence_error), .parity_error(parity_error),
    .rx_busy(rx_busy), .frame_done(frame_done), .frame_bytes(frame_bytes),
    .frame_last_bits(frame_last_bits), .crc_ok(crc_ok), .err_parity(err_parity),
    .err_sequence(err_sequence), .err_overflow(err_overflow),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #10 clk = ~clk;

  typedef struct {
    int               nbytes;
    int               last;
    bit               ok, pe, se, ovf;
    logic [8*MAX-1:0] mem;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_x;
  logic [7:0] fbytes[$];
  bit         in_frame, mpe, mse;
  int         last_nbytes, last_ok;
  int         checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int j = 0; j < 8; j++) begin
      fb = c[0] ^ d[j];
      c  = c >> 1;
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  // Whole-frame reference: truncate to capacity, append partial byte, then
  // accept only if the last two full bytes are the CRC of everything before.
  task automatic finalize(input logic [2:0] b, input logic [7:0] d);
    exp_t        x;
    int          n, st;
    logic [7:0]  m;
    logic [15:0] c;
    n     = fbytes.size();
    st    = (n < MAX) ? n : MAX;
    x.mem = '0;
    for (int i = 0; i < st; i++) x.mem[8*i +: 8] = fbytes[i];
    x.ovf  = (n > MAX);
    x.last = 0;
    if (b != 3'd0) begin
      if (st < MAX) begin
        m = 8'h00;
        for (int k = 0; k < int'(b); k++) m[k] = d[k];
        x.mem[8*st +: 8] = m;
        st++;
        x.last = int'(b);
      end else begin
        x.ovf = 1'b1;
      end
    end
    x.nbytes = st;
    x.pe     = mpe;
    x.se     = mse;
    x.ok     = 1'b0;
    if (st >= 3 && x.last == 0 && !x.pe && !x.se && !x.ovf) begin
      c = 16'h6363;
      for (int i = 0; i < n - 2; i++) c = crc_step(c, fbytes[i]);
      x.ok = (c == {fbytes[n-1], fbytes[n-2]});
    end
    sb.push_back(x);
    last_nbytes = st;
    last_ok     = int'(x.ok);
  endtask

  task automatic drive(input bit s, input bit e, input bit dv, input logic [7:0] d,
                       input logic [2:0] b, input bit p, input bit sq);
    soc = s; eoc = e; data_valid = dv; data = d; data_bits = b;
    parity_error = p; sequence_error = sq;
    if (s) begin
      in_frame = 1'b1; fbytes.delete(); mpe = 1'b0; mse = 1'b0;
    end else if (in_frame) begin
      if (p)  mpe = 1'b1;
      if (sq) mse = 1'b1;
      if (e) begin
        finalize(b, d);
        in_frame = 1'b0;
      end else if (dv) begin
        fbytes.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    soc = 0; eoc = 0; data_valid = 0; data = 8'h00; data_bits = 3'd0;
    parity_error = 0; sequence_error = 0;
  endtask

  task automatic sof();                    drive(1, 0, 0, 8'h00, 3'd0, 0, 0); endtask
  task automatic byt(input logic [7:0] d); drive(0, 0, 1, d, 3'd0, 0, 0);     endtask
  task automatic eof(input logic [2:0] b, input logic [7:0] d); drive(0, 1, 0, d, b, 0, 0); endtask
  task automatic idle();                   drive(0, 0, 0, 8'h00, 3'd0, 0, 0); endtask

  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_frame_done", 1, 0);
      end else begin
        mon_x = sb.pop_front();
        chk("frame_bytes", int'(frame_bytes), mon_x.nbytes);
        chk("frame_last_bits", int'(frame_last_bits), mon_x.last);
        chk("crc_ok", int'(crc_ok), int'(mon_x.ok));
        chk("err_parity", int'(err_parity), int'(mon_x.pe));
        chk("err_sequence", int'(err_sequence), int'(mon_x.se));
        chk("err_overflow", int'(err_overflow), int'(mon_x.ovf));
        chk("rx_busy_at_done", int'(rx_busy), 0);
        for (int i = 0; i < mon_x.nbytes; i++) begin
          rd_addr = BW'(i);
          #1;
          chk($sformatf("rd_data[%0d]", i), int'(rd_data), int'(mon_x.mem[8*i +: 8]));
        end
        rd_addr = BW'(MAX);
        #1;
        chk("rd_data_out_of_range", int'(rd_data), 0);
      end
    end
  end

  initial begin
    logic [15:0] c;
    int          n, wait_cyc;
    logic [7:0]  d;

    rst_n = 0; soc = 0; eoc = 0; data_valid = 0; data = 0; data_bits = 0;
    parity_error = 0; sequence_error = 0; rd_addr = '0;
    in_frame = 0; mpe = 0; mse = 0; last_nbytes = 0; last_ok = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rx_busy", int'(rx_busy), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_frame_bytes", int'(frame_bytes), 0);
    chk("reset_last_bits", int'(frame_last_bits), 0);
    chk("reset_crc_ok", int'(crc_ok), 0);
    chk("reset_errs", int'({err_parity, err_sequence, err_overflow}), 0);
    rst_n = 1;
    idle();

    // Known-good HLTA and the two CRC_A reference frames
    sof(); byt(8'h50); byt(8'h00); byt(8'h57); byt(8'hCD); eof(3'd0, 8'h00); idle(); idle();
    chk("hlta_crc_ok_held", int'(crc_ok), 1);
    sof(); byt(8'h00); byt(8'h00); byt(8'hA0); byt(8'h1F); eof(3'd0, 8'h00); idle(); idle();
    chk("bad_crc_held", int'(crc_ok), 0);
    sof(); byt(8'h00); byt(8'h00); byt(8'hA0); byt(8'h1E); eof(3'd0, 8'h00); idle(); idle();
    chk("good_crc_held", int'(crc_ok), 1);

    // Short 7-bit frame, then error flags
    sof(); eof(3'd7, 8'h26); idle(); idle();
    sof(); byt(8'h93); byt(8'h20); drive(0, 0, 0, 8'h00, 3'd0, 1, 0); eof(3'd0, 8'h00); idle(); idle();
    sof(); byt(8'h93); byt(8'h20); drive(0, 0, 0, 8'h00, 3'd0, 0, 1); eof(3'd0, 8'h00); idle(); idle();

    // Overflow and overflow on a trailing partial byte
    sof(); for (int i = 0; i < 6; i++) byt(8'h10 + 8'(i)); eof(3'd0, 8'h00); idle(); idle();
    sof(); for (int i = 0; i < MAX; i++) byt(8'hE0 + 8'(i)); eof(3'd3, 8'hFF); idle(); idle();

    // Abort by a second soc: only the second frame completes
    sof(); byt(8'h11); byt(8'h22); sof(); byt(8'hAA); eof(3'd0, 8'h00); idle(); idle();

    // Traffic while idle must not disturb held results
    drive(0, 0, 1, 8'h5A, 3'd0, 1, 1); drive(0, 1, 0, 8'h33, 3'd4, 0, 0); idle();
    chk("idle_hold_frame_bytes", int'(frame_bytes), last_nbytes);
    chk("idle_hold_crc_ok", int'(crc_ok), last_ok);
    chk("idle_hold_busy", int'(rx_busy), 0);

    // Reset mid-frame: immediate return, and the following eoc is ignored
    sof(); byt(8'h01); byt(8'h02);
    rst_n = 0; in_frame = 0; last_nbytes = 0; last_ok = 0;
    #1;
    chk("rst_mid_rx_busy", int'(rx_busy), 0);
    chk("rst_mid_frame_bytes", int'(frame_bytes), 0);
    @(posedge clk); #1;
    rst_n = 1;
    eof(3'd0, 8'h00); idle(); idle();
    chk("post_rst_no_busy", int'(rx_busy), 0);

    // Randomized frames, half of them carrying a valid CRC_A trailer
    for (int f = 0; f < 60; f++) begin
      sof();
      if ($urandom_range(0, 7) == 0) begin
        byt(8'($urandom)); sof();
      end
      n = $urandom_range(0, 4);
      c = 16'h6363;
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        c = crc_step(c, d);
        if ($urandom_range(0, 3) == 0) idle();
        drive(0, 0, 1, d, 3'd0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 1) == 1) begin
        d = c[7:0];  byt(d);
        d = c[15:8]; byt(d);
      end
      if ($urandom_range(0, 3) == 0) drive(0, 1, 0, 8'($urandom), 3'($urandom_range(1, 7)), 0, 0);
      else drive(0, 1, $urandom_range(0, 1) == 1, 8'($urandom), 3'd0, $urandom_range(0, 15) == 0, 0);
      repeat ($urandom_range(1, 3)) drive(0, 0, $urandom_range(0, 1) == 1, 8'($urandom), 3'd0, 0, 0);
    end

    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
